// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding select
// encodings, the shadow-stage record and the register-match helper.
package hazard_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_E_WB  = 2'b01;
  localparam logic [1:0] FWD_E_MEM = 2'b10;
  localparam logic [1:0] FWD_D_MEM = 2'b01;
  localparam logic [1:0] FWD_D_WB  = 2'b10;

  typedef struct packed {
    logic [4:0] writeReg;
    logic       regWrite;
    logic       mem2Reg;
  } stage_info_t;

  localparam int STAGE_W = $bits(stage_info_t);

  // Register $0 is hard-wired to zero, so a write to it never produces a value.
  function automatic logic reg_match(input logic [4:0] x, input stage_info_t s);
    return s.regWrite && (s.writeReg != 5'd0) && (s.writeReg == x);
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage: a resettable register that loads zero when a
// bubble is inserted.
module hazard_stage_reg #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] state_d;
  logic [W-1:0] state_q;

  // Next stage contents: a bubble clears every field.
  always_comb begin
    state_d = {W{1'b0}};
    if (bubble) begin
      state_d = {W{1'b0}};
    end else begin
      state_d = d;
    end
  end

  // Stage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= {W{1'b0}};
    end else begin
      state_q <= state_d;
    end
  end

  assign q = state_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller: forwarding selects, load-use / branch stalls, IF/ID
// flush, and a saturating stall-cycle counter, driven from shadow E/M/W state.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       writeRegD,
  input  logic             regWriteD,
  input  logic             mem2RegD,
  input  logic             branchD,
  input  logic             eq,
  output logic [1:0]       fad,
  output logic [1:0]       fbd,
  output logic [1:0]       fae,
  output logic [1:0]       fbe,
  output logic             stall,
  output logic             flushE,
  output logic             flush,
  output logic [CNT_W-1:0] stallCount
);

  localparam int E_W = 10 + STAGE_W;

  stage_info_t        info_d, info_e, info_m, info_w;
  logic [E_W-1:0]     e_d, e_q;
  logic [STAGE_W-1:0] m_q, w_q;
  logic [4:0]         rs_e, rt_e;
  logic               lw_stall, br_stall;
  logic [CNT_W-1:0]   stall_count_d, stall_count_q;

  assign info_d = {writeRegD, regWriteD, mem2RegD};
  assign e_d    = {rsD, rtD, info_d};

  hazard_stage_reg #(.W(E_W)) u_stage_e (
    .clk(clk), .rst(rst), .bubble(flushE), .d(e_d), .q(e_q)
  );
  hazard_stage_reg #(.W(STAGE_W)) u_stage_m (
    .clk(clk), .rst(rst), .bubble(1'b0), .d(e_q[STAGE_W-1:0]), .q(m_q)
  );
  hazard_stage_reg #(.W(STAGE_W)) u_stage_w (
    .clk(clk), .rst(rst), .bubble(1'b0), .d(m_q), .q(w_q)
  );

  assign info_e = stage_info_t'(e_q[STAGE_W-1:0]);
  assign info_m = stage_info_t'(m_q);
  assign info_w = stage_info_t'(w_q);
  assign rs_e   = e_q[E_W-1 -: 5];
  assign rt_e   = e_q[E_W-6 -: 5];

  // Forwarding selects, stall and flush decisions.
  always_comb begin
    fae = FWD_RF;
    fbe = FWD_RF;
    fad = FWD_RF;
    fbd = FWD_RF;

    if (reg_match(rs_e, info_m))      fae = FWD_E_MEM;
    else if (reg_match(rs_e, info_w)) fae = FWD_E_WB;
    else                              fae = FWD_RF;

    if (reg_match(rt_e, info_m))      fbe = FWD_E_MEM;
    else if (reg_match(rt_e, info_w)) fbe = FWD_E_WB;
    else                              fbe = FWD_RF;

    // A load in MEM has no data yet; the branch stall covers that case.
    if (reg_match(rsD, info_m) && !info_m.mem2Reg) fad = FWD_D_MEM;
    else if (reg_match(rsD, info_w))               fad = FWD_D_WB;
    else                                           fad = FWD_RF;

    if (reg_match(rtD, info_m) && !info_m.mem2Reg) fbd = FWD_D_MEM;
    else if (reg_match(rtD, info_w))               fbd = FWD_D_WB;
    else                                           fbd = FWD_RF;

    lw_stall = info_e.mem2Reg && (reg_match(rsD, info_e) || reg_match(rtD, info_e));
    br_stall = branchD && (reg_match(rsD, info_e) || reg_match(rtD, info_e) ||
               (info_m.mem2Reg && (reg_match(rsD, info_m) || reg_match(rtD, info_m))));

    stall  = lw_stall || br_stall;
    flushE = stall;
    flush  = branchD && eq && !stall;
  end

  // Saturating stall-cycle counter next value.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Stall-cycle counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= {CNT_W{1'b0}};
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed vector table, reset and
// saturation sequences, then random stimulus against a behavioural model.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rsD = 5'd0, rtD = 5'd0, writeRegD = 5'd0;
  logic        regWriteD = 1'b0, mem2RegD = 1'b0, branchD = 1'b0, eq = 1'b0;
  logic [1:0]  fad, fbd, fae, fbe;
  logic        stall, flushE, flush;
  logic [15:0] stallCount;
  logic [1:0]  s_fad, s_fbd, s_fae, s_fbe;
  logic        s_stall, s_flushE, s_flush;
  logic [1:0]  s_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .writeRegD(writeRegD),
    .regWriteD(regWriteD), .mem2RegD(mem2RegD), .branchD(branchD), .eq(eq),
    .fad(fad), .fbd(fbd), .fae(fae), .fbe(fbe), .stall(stall),
    .flushE(flushE), .flush(flush), .stallCount(stallCount)
  );

  hazard_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .writeRegD(writeRegD),
    .regWriteD(regWriteD), .mem2RegD(mem2RegD), .branchD(branchD), .eq(eq),
    .fad(s_fad), .fbd(s_fbd), .fae(s_fae), .fbe(s_fbe), .stall(s_stall),
    .flushE(s_flushE), .flush(s_flush), .stallCount(s_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input int rs, input int rt, input int wd, input bit rw,
                       input bit ld, input bit br, input bit e);
    rsD = 5'(rs); rtD = 5'(rt); writeRegD = 5'(wd);
    regWriteD = rw; mem2RegD = ld; branchD = br; eq = e;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int rs, rt, wd; bit rw, ld, br, e;
    int fad, fbd, fae, fbe; bit st, fl; int cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic tv(input int rs, input int rt, input int wd, input bit rw, input bit ld,
                    input bit br, input bit e, input int xfad, input int xfbd,
                    input int xfae, input int xfbe, input bit st, input bit fl, input int cnt);
    vec_t v;
    v = '{rs, rt, wd, rw, ld, br, e, xfad, xfbd, xfae, xfbe, st, fl, cnt};
    tbl.push_back(v);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int dest; bit wr; bit ld; int rs; int rt; } ent_t;
  ent_t pipe[3];  // 0 = execute, 1 = memory, 2 = writeback
  int   m_cnt, m_sat;

  function automatic bit prod(input int s, input int r);
    return pipe[s].wr && pipe[s].dest != 0 && pipe[s].dest == r;
  endfunction

  function automatic int exe_sel(input int r);
    if (prod(1, r)) return 2;
    if (prod(2, r)) return 1;
    return 0;
  endfunction

  function automatic int dec_sel(input int r);
    if (prod(1, r) && !pipe[1].ld) return 1;
    if (prod(2, r)) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
    m_cnt = 0;
    m_sat = 0;
  endtask

  task automatic model_step();
    int rs, rt;
    bit lu, bs, st;
    #2;
    rs = int'(rsD);
    rt = int'(rtD);
    lu = pipe[0].ld && (prod(0, rs) || prod(0, rt));
    bs = branchD && (prod(0, rs) || prod(0, rt) || (pipe[1].ld && (prod(1, rs) || prod(1, rt))));
    st = lu || bs;
    chk("fae", fae, exe_sel(pipe[0].rs));
    chk("fbe", fbe, exe_sel(pipe[0].rt));
    chk("fad", fad, dec_sel(rs));
    chk("fbd", fbd, dec_sel(rt));
    chk("stall", stall, st);
    chk("flushE", flushE, st);
    chk("flush", flush, branchD && eq && !st);
    chk("stallCount", stallCount, m_cnt);
    chk("sat_stall", s_stall, st);
    chk("sat_fae", s_fae, exe_sel(pipe[0].rs));
    chk("sat_fbd", s_fbd, dec_sel(rt));
    chk("sat_cnt", s_cnt, m_sat);
    @(posedge clk);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    if (st) pipe[0] = '{default: 0};
    else    pipe[0] = '{int'(writeRegD), regWriteD, mem2RegD, rs, rt};
    if (st) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_sat < 3) m_sat++;
    end
    #2;
  endtask

  initial begin
    // rs rt wd rw ld br eq | fad fbd fae fbe st fl cnt
    tv(1,2,3,1,0,0,0, 0,0,0,0,0,0,0);   // add $3,$1,$2
    tv(3,5,4,1,0,0,0, 0,0,0,0,0,0,0);   // sub $4,$3,$5
    tv(0,0,0,0,0,0,0, 0,0,2,0,0,0,0);   // sub in E: fae from MEM
    tv(0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
    tv(0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
    tv(1,2,2,1,1,0,0, 0,0,0,0,0,0,0);   // lw $2,0($1)
    tv(2,2,4,1,0,0,0, 0,0,0,0,1,0,0);   // add $4,$2,$2: load-use stall
    tv(2,2,4,1,0,0,0, 0,0,0,0,0,0,1);
    tv(0,0,0,0,0,0,0, 0,0,1,1,0,0,1);   // add in E: forward from WB
    tv(1,0,0,1,0,0,0, 0,0,0,0,0,0,1);   // writes $0
    tv(0,0,6,1,0,0,0, 0,0,0,0,0,0,1);   // reads $0
    tv(0,0,0,0,0,0,0, 0,0,0,0,0,0,1);
    tv(0,0,0,0,0,0,0, 0,0,0,0,0,0,1);
    tv(0,0,0,0,0,0,0, 0,0,0,0,0,0,1);
    tv(1,5,5,1,1,0,0, 0,0,0,0,0,0,1);   // lw $5
    tv(5,6,0,0,0,1,1, 0,0,0,0,1,0,1);   // beq $5,$6 stall 1
    tv(5,6,0,0,0,1,1, 0,0,0,0,1,0,2);   // stall 2
    tv(5,6,0,0,0,1,1, 2,0,0,0,0,1,3);   // resolves from WB, flush
    tv(0,0,0,0,0,0,0, 0,0,0,0,0,0,3);
    tv(1,2,7,1,0,0,0, 0,0,0,0,0,0,3);   // add $7
    tv(1,2,7,1,0,0,0, 0,0,0,0,0,0,3);   // add $7 again
    tv(7,7,8,1,0,0,0, 1,1,0,0,0,0,3);   // add $8,$7,$7: decode from MEM
    tv(1,2,9,1,0,0,0, 0,0,2,2,0,0,3);   // $7 in M and W: MEM wins
    tv(9,0,0,0,0,1,0, 0,0,0,0,1,0,3);   // beq $9,$0 after ALU op: stall
    tv(9,0,0,0,0,1,0, 1,0,0,0,0,0,4);   // then fad from MEM
    tv(0,0,0,0,0,0,0, 0,0,1,0,0,0,4);

    #7;
    chk("reset_fad", fad, 0);
    chk("reset_fae", fae, 0);
    chk("reset_stall", stall, 0);
    chk("reset_flush", flush, 0);
    chk("reset_count", stallCount, 0);
    #2 rst = 1'b0;
    @(posedge clk);
    #2;

    foreach (tbl[i]) begin
      drive(tbl[i].rs, tbl[i].rt, tbl[i].wd, tbl[i].rw, tbl[i].ld, tbl[i].br, tbl[i].e);
      #2;
      chk($sformatf("v%0d_fad", i), fad, tbl[i].fad);
      chk($sformatf("v%0d_fbd", i), fbd, tbl[i].fbd);
      chk($sformatf("v%0d_fae", i), fae, tbl[i].fae);
      chk($sformatf("v%0d_fbe", i), fbe, tbl[i].fbe);
      chk($sformatf("v%0d_stall", i), stall, tbl[i].st);
      chk($sformatf("v%0d_flushE", i), flushE, tbl[i].st);
      chk($sformatf("v%0d_flush", i), flush, tbl[i].fl);
      chk($sformatf("v%0d_cnt", i), stallCount, tbl[i].cnt);
      @(posedge clk);
      #2;
    end

    // Reset to a known state, then reset in the middle of a load-use stall.
    drive(0,0,0,0,0,0,0);
    rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    drive(1,2,2,1,1,0,0);           // lw $2
    model_step();
    drive(2,2,4,1,0,0,0);           // add $4,$2,$2
    #2;
    chk("midrst_pre_stall", stall, 1);
    rst = 1'b1;
    #1;
    chk("midrst_stall", stall, 0);
    chk("midrst_flushE", flushE, 0);
    chk("midrst_count", stallCount, 0);
    chk("midrst_sat_count", s_cnt, 0);
    chk("midrst_sel", {fad, fbd, fae, fbe}, 0);
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk);
    #2;

    // Repeated load-use stalls: narrow counter saturates at 3.
    for (int k = 0; k < 5; k++) begin
      drive(1,2,2,1,1,0,0);
      model_step();
      drive(2,2,4,1,0,0,0);
      model_step();
      model_step();
    end
    chk("sat_hold", s_cnt, 3);
    chk("wide_count", stallCount, 5);

    // Random stimulus against the model.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      model_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage 32-bit MIPS-style core. It drives the hazard inputs of the datapath: decode-stage forwarding selects `fad`/`fbd`, execute-stage selects `fae`/`fbe`, the stall signals and the IF/ID `flush`. It holds its own shadow pipeline (E, M, W) of destination-register and write-control information, so the datapath only presents decode-stage fields each cycle. A saturating stall-cycle counter is included for performance debug.

## Interface

Parameters:
- `CNT_W`, 16: width of the stall-cycle counter.

Ports (reset `rst`, asynchronous, active-high; clock `clk`):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `rsD`, `rtD`  in  5 each  source register fields of the instruction in decode.
- `writeRegD`  in  5  destination register of the decode instruction, already resolved by `regDst`.
- `regWriteD`, `mem2RegD`, `branchD`  in  1 each  decode control bits.
- `eq`  in  1  decode-stage branch comparison result, taken from the datapath.
- `fad`, `fbd`  out  2 each  decode compare operand select. 00 = register file, 01 = MEM ALU result, 10 = WB result.
- `fae`, `fbe`  out  2 each  execute ALU operand select. 00 = ID/EX value, 01 = WB result, 10 = MEM ALU result.
- `stall`  out  1  freeze PC and the IF/ID register.
- `flushE`  out  1  insert a bubble into ID/EX.
- `flush`  out  1  clear IF/ID (taken branch).
- `stallCount`  out  `CNT_W`  saturating count of stall cycles.

## Operation

- Shadow stages E, M and W each hold `{writeReg[4:0], regWrite, mem2Reg}`. Stage E also holds `rsE` and `rtE`.
- On every clock: W <= M, M <= E. E <= bubble (all zero) if `flushE`, otherwise the decode inputs.
- "Match(x, s)" means: `regWrite_s` = 1, `writeReg_s` != 0, and `writeReg_s` == x. Register $0 never matches.
- `fae`:
  - 10 if Match(`rsE`, M);
  - else 01 if Match(`rsE`, W);
  - else 00.
  - MEM has priority over WB. `fbe` is the same, using `rtE`.
- `fad`:
  - 01 if Match(`rsD`, M) and `mem2RegM` = 0;
  - else 10 if Match(`rsD`, W);
  - else 00.
  - `fbd` is the same, using `rtD`.
- `lwStall` = `mem2RegE` & (Match(`rsD`, E) | Match(`rtD`, E)).
- `brStall` = `branchD` & ( Match(`rsD` or `rtD`, E) | (`mem2RegM` & Match(`rsD` or `rtD`, M)) ).
- `stall` = `flushE` = `lwStall` | `brStall`.
- `flush` = `branchD` & `eq` & ~`stall`. A stalled branch never flushes; it resolves on a later cycle.
- `stallCount` increments each clock with `stall` = 1 and saturates at all-ones.

## Timing

- All outputs are combinational from the current decode inputs plus shadow state. There is no added latency.
- Shadow state and the counter change only on the `clk` rising edge, or asynchronously on `rst`.
- Reset clears all shadow stages and `stallCount` to 0.
  - With decode inputs at 0, all outputs are 0 immediately after reset.
  - `rst` asserted mid-stall clears the pending hazard at once; `stall` drops as soon as E and M are zero.
- A load-use hazard produces exactly 1 stall cycle; the next cycle forwards from WB via `fae`/`fbe` = 01.
- A branch depending on the ALU op in E gives 1 stall cycle, then `fad` = 01.
- A branch depending on a load in E gives 2 stall cycles, then `fad` = 10.
- When a load-use hazard and a branch hazard coincide, one combined `stall` is issued and the counter increments by 1 per cycle.
- Simultaneous M and W matches on the same register select M.

## Structure

- Shared package `hazard_pkg`:
  - `FWD_RF` = 2'b00.
  - Execute selects: `FWD_E_WB` = 2'b01, `FWD_E_MEM` = 2'b10.
  - Decode selects: `FWD_D_MEM` = 2'b01, `FWD_D_WB` = 2'b10.
  - Struct typedef `stage_info_t` = `{writeReg, regWrite, mem2Reg}`.
- Sub-module `hazard_stage_reg`: one resettable shadow stage with a bubble (clear) input, instantiated three times.
- Top level contains only the match logic, output logic and counter.

## Test plan

- Reset, then decode `add $3,$1,$2` followed by `sub $4,$3,$5` -> on the `sub` execute cycle `fae` = 10, `fbe` = 00, `stall` = 0.
- `lw $2,0($1)` then `add $4,$2,$2` -> 1 cycle with `stall` = `flushE` = 1. Next cycle `fae` = `fbe` = 01. `stallCount` = 1.
- Instruction writing $0, followed by a reader of $0 -> every forward select is 00 and `stall` = 0.
- `lw $5`, then `beq $5,$6` with `eq` = 1 -> 2 stall cycles with `flush` = 0. Then `fad` = 10 and `flush` = 1 for 1 cycle.
- Same register written in both M and W, read in E -> `fae` = 10.
- Assert `rst` during a load-use stall -> `stall`, `stallCount` and all selects are 0 at once. Repeat stalls until `stallCount` saturates with `CNT_W` = 2 -> holds at 3.
